// File: rtl/approx_pkg.sv
// Shared types, widths and helpers for the pipelined approximate adder.
// Latency: none (package only).
// Backpressure: not applicable.
package approx_pkg;

   // Per-transaction approximation style for the low ke bits
   typedef enum logic {
      APX_LOA   = 1'b0,  // low bits are a|b, carry into bit ke is a&b of bit ke-1
      APX_TRUNC = 1'b1   // low bits forced to zero, no carry into bit ke
   } apx_mode_e;

   localparam int ERR_ACC_W = 40;
   localparam int ERR_CNT_W = 32;

   // Widest mask lsb_mask can describe; callers truncate to their own width
   localparam int MASK_W = 128;

   // Bit i of the result is set when bit i is inside the approximated region
   function automatic logic [MASK_W-1:0] lsb_mask(input int unsigned ke);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         m[i] = (i < ke);
      end
      return m;
   endfunction

endpackage

// File: rtl/approx_seg_stage.sv
// One pipeline segment: adds operand slice IDX with the carry from the previous stage.
// Latency: 1 cycle (registered output).
// Backpressure: holds when full and downstream not ready; rdy_o = !vld_q | rdy_i.
module approx_seg_stage
   import approx_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEGS  = 4,
   parameter int IDX   = 0,
   parameter int KW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             vld_i,
   output logic             rdy_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [KW-1:0]    ke_i,
   input  apx_mode_e        mode_i,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             cin_i,
`ifdef APPROX_ERR_MON_EN
   input  logic [WIDTH-1:0] ex_sum_i,
   input  logic             ex_cin_i,
   output logic [WIDTH-1:0] ex_sum_o,
   output logic             ex_cout_o,
`endif
   output logic             vld_o,
   input  logic             rdy_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [KW-1:0]    ke_o,
   output apx_mode_e        mode_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int SW = WIDTH / SEGS;
   localparam int LO = IDX * SW;

   logic             vld_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
   logic [KW-1:0]    ke_q;
   apx_mode_e        mode_q;
   logic             cout_q, cout_d;
   logic [SW:0]      seg_mask;

   assign rdy_o = !vld_q || rdy_i;

   // Approximated-bit mask seen from this segment; bit SW is the first bit of the next one
   assign seg_mask = (SW+1)'(lsb_mask(32'(ke_i)) >> LO);

   // Segment adder: approximate region below ke, exact ripple from ke upward
   always_comb begin
      logic c;
      sum_d = sum_i;
      c     = cin_i;
      for (int j = 0; j < SW; j++) begin
         if (seg_mask[j]) begin
            sum_d[LO+j] = (mode_i == APX_LOA) ? (a_i[LO+j] | b_i[LO+j]) : 1'b0;
            // only the topmost approximated bit may generate a carry, and only in LOA
            c = (mode_i == APX_LOA) && !seg_mask[j+1] && a_i[LO+j] && b_i[LO+j];
         end else begin
            sum_d[LO+j] = a_i[LO+j] ^ b_i[LO+j] ^ c;
            c = (a_i[LO+j] & b_i[LO+j]) | (c & (a_i[LO+j] ^ b_i[LO+j]));
         end
      end
      cout_d = c;
   end

   // Stage register: advances when empty or when downstream accepts
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         vld_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         ke_q   <= '0;
         mode_q <= APX_LOA;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (rdy_o) begin
         vld_q <= vld_i;
         if (vld_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            ke_q   <= ke_i;
            mode_q <= mode_i;
            sum_q  <= sum_d;
            cout_q <= cout_d;
         end
      end
   end

   assign vld_o  = vld_q;
   assign a_o    = a_q;
   assign b_o    = b_q;
   assign ke_o   = ke_q;
   assign mode_o = mode_q;
   assign sum_o  = sum_q;
   assign cout_o = cout_q;

`ifdef APPROX_ERR_MON_EN
   logic [WIDTH-1:0] ex_sum_q, ex_sum_d;
   logic             ex_cout_q, ex_cout_d;

   // Exact shadow adder for the same slice
   always_comb begin
      logic c;
      ex_sum_d = ex_sum_i;
      c        = ex_cin_i;
      for (int j = 0; j < SW; j++) begin
         ex_sum_d[LO+j] = a_i[LO+j] ^ b_i[LO+j] ^ c;
         c = (a_i[LO+j] & b_i[LO+j]) | (c & (a_i[LO+j] ^ b_i[LO+j]));
      end
      ex_cout_d = c;
   end

   // Shadow register moves in lockstep with the approximate one
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ex_sum_q  <= '0;
         ex_cout_q <= 1'b0;
      end else if (rdy_o && vld_i) begin
         ex_sum_q  <= ex_sum_d;
         ex_cout_q <= ex_cout_d;
      end
   end

   assign ex_sum_o  = ex_sum_q;
   assign ex_cout_o = ex_cout_q;
`endif

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder (LOA / truncate, per-transaction depth); APPROX_ERR_MON_EN adds an error monitor.
// Latency: SEGS cycles from input handshake to out_valid; one result per cycle when unstalled.
// Backpressure: valid/ready; in_ready is combinational through the stall chain, SEGS transactions in flight.
module approx_add_pipe
   import approx_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEGS  = 4,
   parameter int KMAX  = WIDTH / 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic [$clog2(KMAX+1)-1:0]  k,
   input  logic                       mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH:0]             sum
`ifdef APPROX_ERR_MON_EN
   ,
   input  logic                       err_clr,
   output logic [ERR_CNT_W-1:0]       err_cnt,
   output logic [WIDTH:0]             err_max,
   output logic [ERR_ACC_W-1:0]       err_acc
`endif
);

   localparam int KW = $clog2(KMAX + 1);

   if (WIDTH % SEGS != 0) begin : g_bad_segs
      $error("approx_add_pipe: WIDTH must be a multiple of SEGS");
   end
   if (KMAX < 1 || KMAX > WIDTH) begin : g_bad_kmax
      $error("approx_add_pipe: KMAX must be in 1..WIDTH");
   end

   // Chain index s is the input of stage s; index SEGS is the pipeline output
   logic             vld_c  [SEGS+1];
   logic             rdy_c  [SEGS+1];
   logic [WIDTH-1:0] a_c    [SEGS+1];
   logic [WIDTH-1:0] b_c    [SEGS+1];
   logic [KW-1:0]    ke_c   [SEGS+1];
   apx_mode_e        mode_c [SEGS+1];
   logic [WIDTH-1:0] sum_c  [SEGS+1];
   logic             cout_c [SEGS+1];

   // Clamp the requested depth to KMAX at the input so it travels pre-clamped
   assign ke_c[0]   = (k > KW'(KMAX)) ? KW'(KMAX) : k;
   assign vld_c[0]  = in_valid;
   assign a_c[0]    = a;
   assign b_c[0]    = b;
   assign mode_c[0] = apx_mode_e'(mode);
   assign sum_c[0]  = '0;
   assign cout_c[0] = 1'b0;

   assign rdy_c[SEGS] = out_ready;
   assign in_ready    = rdy_c[0];
   assign out_valid   = vld_c[SEGS];
   assign sum         = {cout_c[SEGS], sum_c[SEGS]};

   // Operands and settings are not needed after the last segment
   logic unused_tail;
   assign unused_tail = ^{a_c[SEGS], b_c[SEGS], ke_c[SEGS], mode_c[SEGS]};

`ifdef APPROX_ERR_MON_EN
   logic [WIDTH-1:0] ex_sum_c  [SEGS+1];
   logic             ex_cout_c [SEGS+1];
   assign ex_sum_c[0]  = '0;
   assign ex_cout_c[0] = 1'b0;
`endif

   for (genvar s = 0; s < SEGS; s++) begin : g_seg
      approx_seg_stage #(
         .WIDTH (WIDTH),
         .SEGS  (SEGS),
         .IDX   (s),
         .KW    (KW)
      ) u_stage (
         .clk_i     (clk),
         .rst_n_i   (rst_n),
         .vld_i     (vld_c[s]),
         .rdy_o     (rdy_c[s]),
         .a_i       (a_c[s]),
         .b_i       (b_c[s]),
         .ke_i      (ke_c[s]),
         .mode_i    (mode_c[s]),
         .sum_i     (sum_c[s]),
         .cin_i     (cout_c[s]),
`ifdef APPROX_ERR_MON_EN
         .ex_sum_i  (ex_sum_c[s]),
         .ex_cin_i  (ex_cout_c[s]),
         .ex_sum_o  (ex_sum_c[s+1]),
         .ex_cout_o (ex_cout_c[s+1]),
`endif
         .vld_o     (vld_c[s+1]),
         .rdy_i     (rdy_c[s+1]),
         .a_o       (a_c[s+1]),
         .b_o       (b_c[s+1]),
         .ke_o      (ke_c[s+1]),
         .mode_o    (mode_c[s+1]),
         .sum_o     (sum_c[s+1]),
         .cout_o    (cout_c[s+1])
      );
   end

`ifdef APPROX_ERR_MON_EN
   logic [WIDTH:0]         ex_full, err_e;
   logic                   hs;
   logic [ERR_ACC_W:0]     acc_sum;
   logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]         max_q, max_d;
   logic [ERR_ACC_W-1:0]   acc_q, acc_d;

   assign ex_full = {ex_cout_c[SEGS], ex_sum_c[SEGS]};
   // LOA can overshoot the exact sum, so take the absolute difference
   assign err_e   = (ex_full >= sum) ? (ex_full - sum) : (sum - ex_full);
   assign hs      = out_valid && out_ready;
   assign acc_sum = {1'b0, acc_q} + (ERR_ACC_W+1)'(err_e);

   // Monitor next state: clear wins but still counts a coincident handshake
   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      acc_d = acc_q;
      if (err_clr) begin
         cnt_d = {{(ERR_CNT_W-1){1'b0}}, hs && (err_e != '0)};
         max_d = hs ? err_e : '0;
         acc_d = hs ? ERR_ACC_W'(err_e) : '0;
      end else if (hs) begin
         if (err_e != '0 && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (err_e > max_q) begin
            max_d = err_e;
         end
         acc_d = acc_sum[ERR_ACC_W] ? '1 : acc_sum[ERR_ACC_W-1:0];
      end
   end

   // Monitor registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         max_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         max_q <= max_d;
         acc_q <= acc_d;
      end
   end

   assign err_cnt = cnt_q;
   assign err_max = max_q;
   assign err_acc = acc_q;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe (WIDTH=16, SEGS=4, KMAX=8) with a scoreboard queue.
// Latency: expects results SEGS cycles after acceptance when unstalled.
// Backpressure: exercises stalls, hold-stability and mid-flight reset.
module tb_approx_add_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, mode, out_valid, out_ready;
   logic [15:0] a, b;
   logic [3:0]  k;
   logic [16:0] sum;
`ifdef APPROX_ERR_MON_EN
   logic        err_clr;
   logic [31:0] err_cnt;
   logic [16:0] err_max;
   logic [39:0] err_acc;
`endif

   always #5 clk = ~clk;

   approx_add_pipe #(.WIDTH(16), .SEGS(4), .KMAX(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .k         (k),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef APPROX_ERR_MON_EN
      ,
      .err_clr   (err_clr),
      .err_cnt   (err_cnt),
      .err_max   (err_max),
      .err_acc   (err_acc)
`endif
   );

   typedef struct {
      logic [16:0] sum;
      int          cyc;
      bit          lat;
   } sb_t;

   sb_t sb_q[$];
   int  n_chk = 0, n_fail = 0;
   int  cyc = 0, acc_cnt = 0, n_out = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: exact upper part above ke, approximated lower part below it
   function automatic logic [16:0] model(input logic [15:0] av, input logic [15:0] bv,
                                         input int kv, input logic mv);
      int          ke;
      logic [16:0] lo, hi;
      logic        c;
      ke = (kv > 8) ? 8 : kv;
      if (ke == 0) return {1'b0, av} + {1'b0, bv};
      lo = {1'b0, av | bv} & ((17'd1 << ke) - 17'd1);
      c  = av[ke-1] & bv[ke-1];
      if (mv) return (17'(av >> ke) + 17'(bv >> ke)) << ke;
      hi = (17'(av >> ke) + 17'(bv >> ke) + 17'(c)) << ke;
      return hi | lo;
   endfunction

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] kv,
                       input logic mv, input logic [16:0] ev, input bit lat = 1'b0);
      int waits = 0;
      bit done  = 1'b0;
      sb_t e;
      in_valid = 1'b1;
      a = av; b = bv; k = kv; mode = mv;
      while (!done) begin
         @(negedge clk);
         if (in_ready && rst_n) begin
            e.sum = ev; e.cyc = cyc; e.lat = lat;
            sb_q.push_back(e);
            acc_cnt++;
            done = 1'b1;
         end else if (waits > 200) begin
            chk("send_timeout", in_ready, 1);
            done = 1'b1;
         end
         waits++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_left", sb_q.size(), 0);
   endtask

   // Output side: scoreboard pop plus hold-stability while stalled
   sb_t         mon_e;
   logic        stall_prev = 1'b0;
   logic [16:0] sum_prev   = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, sum_prev);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("spurious_out", out_valid, 0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("sum", sum, mon_e.sum);
               if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 4);
               n_out++;
            end
         end
         stall_prev <= out_valid && !out_ready;
         sum_prev   <= sum;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rnd_done;
      int          out_base;
      int          t;
      logic [15:0] ra, rb;
      logic [3:0]  rk;
      logic        rm;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; k = '0; mode = 1'b0;
`ifdef APPROX_ERR_MON_EN
      err_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef APPROX_ERR_MON_EN
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_acc", err_acc, 0);
`endif
      rst_n = 1'b1;

      // Exact add with latency check, then LOA / truncate / clamp cases
      send(16'hFFFF, 16'h0001, 4'd0, 1'b0, 17'h10000, 1'b1);
      drain();
      send(16'h000F, 16'h0001, 4'd4,  1'b0, 17'h0000F);
      send(16'h0008, 16'h0008, 4'd4,  1'b0, 17'h00018);
      send(16'h00FF, 16'h0011, 4'd4,  1'b1, 17'h00100);
      send(16'h12FF, 16'h03FF, 4'd15, 1'b1, 17'h01500);
      send(16'h00FF, 16'h0080, 4'd15, 1'b0, 17'h001FF);
      send(16'h8001, 16'h8001, 4'd1,  1'b0, 17'h10003);
      drain();

      // Random traffic with random output stalls
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               ra = 16'($urandom); rb = 16'($urandom);
               rk = 4'($urandom_range(0, 15)); rm = 1'($urandom_range(0, 1));
               send(ra, rb, rk, rm, model(ra, rb, int'(rk), rm));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Backpressure: 6 queued with the output blocked for 10 cycles
      out_ready = 1'b0;
      acc_cnt   = 0;
      out_base  = n_out;
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               ra = 16'(i * 16'h1111); rb = 16'(i * 16'h0101);
               send(ra, rb, 4'(i), 1'(i % 2), model(ra, rb, i, 1'(i % 2)));
            end
         end
         begin
            repeat (10) @(posedge clk);
            #2;
            chk("bp_accepted", acc_cnt, 4);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_emerged", n_out - out_base, 6);

      // Reset with three transactions in flight
      send(16'h1234, 16'h1111, 4'd0, 1'b0, 17'h02345);
      send(16'h2222, 16'h1111, 4'd0, 1'b0, 17'h03333);
      send(16'h4444, 16'h1111, 4'd0, 1'b0, 17'h05555);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb_q.delete();
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_sum", sum, 0);
      out_base = n_out;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_rst_no_output", n_out - out_base, 0);

`ifdef APPROX_ERR_MON_EN
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("clr_err_cnt", err_cnt, 0);
      send(16'h000F, 16'h0001, 4'd4, 1'b0, 17'h0000F);
      send(16'h00FF, 16'h0011, 4'd4, 1'b1, 17'h00100);
      send(16'h00FF, 16'h0011, 4'd0, 1'b0, 17'h00110);
      drain();
      @(posedge clk); #1;
      chk("mon_err_cnt", err_cnt, 2);
      chk("mon_err_max", err_max, 16);
      chk("mon_err_acc", err_acc, 17);

      // Clear coinciding with a handshake of a 16-error result
      out_ready = 1'b0;
      send(16'h00FF, 16'h0011, 4'd4, 1'b1, 17'h00100);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("mon_wait_valid", out_valid, 1);
      err_clr   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("clr_hs_err_cnt", err_cnt, 1);
      chk("clr_hs_err_acc", err_acc, 16);
      chk("clr_hs_err_max", err_max, 16);
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/approx_add_pipe.md
# approx_add_pipe

Parametrised, pipelined approximate unsigned adder with run-time selectable approximation depth and mode. It generalises our fixed 16-bit combinational approximate adders. Width, pipeline depth and approximation are now configurable, and a valid/ready handshake carries each transaction's settings with its data. It sits in the datapath in front of accelerators that trade accuracy for power. An optional monitor measures the error actually introduced.

## Interface
Parameters:
- WIDTH, 16, operand width; sum is WIDTH+1 bits
- SEGS, 4, pipeline segments; WIDTH % SEGS == 0 (elaboration error otherwise)
- KMAX, WIDTH/2, largest permitted approximated-LSB count

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept
- a, b  in  WIDTH  operands
- k  in  $clog2(KMAX+1)  approximated LSB count for this transaction
- mode  in  1  0 = LOA (lower-part OR), 1 = truncate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- sum  out  WIDTH+1  approximate sum
- err_clr  in  1  monitor clear (APPROX_ERR_MON_EN only)
- err_cnt  out  32  transactions with nonzero error, saturating (APPROX_ERR_MON_EN only)
- err_max  out  WIDTH+1  largest |exact−approx| seen (APPROX_ERR_MON_EN only)
- err_acc  out  40  sum of |exact−approx|, saturating (APPROX_ERR_MON_EN only)

## Operation
- Effective depth ke = min(k, KMAX). ke = 0 gives an exact sum.
- LOA mode:
  - sum[i] = a[i] | b[i] for i < ke.
  - Carry into bit ke = a[ke−1] & b[ke−1].
- Truncate mode: sum[i] = 0 for i < ke; carry into bit ke = 0.
- Bits ≥ ke use an exact ripple add. sum[WIDTH] = final carry out.
- ke and mode are captured with the operands on the input handshake and travel with them.
- Segment s (s = 0..SEGS−1) adds operand bits [s·W/S +: W/S] plus the carry registered from stage s−1. Later stages carry the unprocessed operand slices and the completed lower sum bits forward.
- Handshake and flow control:
  - Stage j advances when !valid_j | ready_(j+1). The last stage's ready is out_ready.
  - in_ready = ready of stage 0; it is combinational through the stall chain.
  - No transaction is dropped, duplicated or reordered.
  - out_valid/sum hold stable while out_valid & !out_ready.
- Reset (rst_n low at an edge):
  - All stage valids clear, so out_valid = 0 and sum = 0. In-flight data is discarded.
  - in_ready = 1 from the first cycle after reset.
- Monitor:
  - An exact sum is pipelined alongside the approximate one.
  - On each out_valid & out_ready, e = |exact − sum|.
  - If e ≠ 0, err_cnt increments.
  - err_max = max(err_max, e).
  - err_acc += e.
  - err_cnt and err_acc saturate at all-ones.
  - err_clr has priority: counters load that cycle's transaction values if a handshake coincides, else 0.
  - Reset clears all monitor outputs.

## Timing
- Latency: SEGS cycles from input handshake to out_valid, with no stall.
- Throughput: one transaction per cycle while out_ready = 1.
- Capacity: SEGS transactions in flight. With out_ready held low, in_ready deasserts once all stages are valid.
- Monitor outputs update the cycle after the output handshake.

## Configuration
- APPROX_ERR_MON_EN defined:
  - The exact-sum shadow pipeline and the monitor are built.
  - err_clr, err_cnt, err_max and err_acc exist.
- APPROX_ERR_MON_EN undefined:
  - The monitor ports are absent.
  - No shadow pipeline is built; power and area cover the approximate path only.

## Structure
- Shared package approx_pkg holds:
  - apx_mode_e enum (APX_LOA = 0, APX_TRUNC = 1)
  - ERR_ACC_W = 40, ERR_CNT_W = 32
  - function lsb_mask(ke) for the approximated-bit mask
- One sub-module, approx_seg_stage: a single pipeline segment holding the segment adder, the valid/ready register and the pass-through fields. It is instantiated SEGS times in a generate loop.

## Test plan
All cases use WIDTH=16, SEGS=4, KMAX=8.
- Exact add: k=0, a=0xFFFF, b=0x0001 -> sum=0x10000, out_valid 4 cycles after accept.
- LOA: k=4, a=0x000F, b=0x0001 -> sum=0x000F (exact 0x0010, error 1). With a=0x0008, b=0x0008 -> sum=0x0018.
- Truncate: k=4, a=0x00FF, b=0x0011 -> sum=0x0100 (exact 0x0110). k=15 is clamped and behaves as k=8.
- Backpressure: stream 6 transactions with out_ready=0 for 10 cycles -> 4 accepted, then in_ready=0. After release, all 6 emerge in order, unaltered.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle, none of the 3 ever appears, in_ready=1.
- Monitor (macro on):
  - err_clr, then the LOA (error 1) and truncate (error 16) cases above plus one exact add -> err_cnt=2, err_max=16, err_acc=17.
  - err_clr coincident with a 16-error handshake -> err_cnt=1, err_acc=16.
